multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 83 ++++++++
 rtl/multicycle_control_perf.sv | 25 ++
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared parameters for the multicycle controller: state encodings, opcodes,
// datapath select codes and the control-word layout.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_LUI    = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    // ALUOp must stay aligned with the ALU controller's decode
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operation codes used by the ALU controller
    localparam logic [2:0] OPADD = 3'b000;
    localparam logic [2:0] OPSUB = 3'b001;
    localparam logic [2:0] OPAND = 3'b010;
    localparam logic [2:0] OPOR  = 3'b011;
    localparam logic [2:0] OPSLT = 3'b101;

    typedef struct packed {
        logic       mem_req;
        logic       pc_update;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

    function automatic state_t decode_next(input logic [6:0] opcode);
        state_t s;
        case (opcode)
            OPC_LW, OPC_SW: s = S_MEMADR;
            OPC_RTYPE:      s = S_EXECR;
            OPC_ITYPE:      s = S_EXECI;
            OPC_BEQ:        s = S_BRANCH;
            OPC_JAL:        s = S_JAL;
            OPC_LUI:        s = S_LUI;
            default:        s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_perf.sv
// Cycle and retired-instruction counters for the multicycle controller.
// Both wrap modulo 2^CNT_W; cleared by synchronous reset.
module multicycle_control_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: Moore FSM driving datapath strobes and selects.
// Performance counters are built only when PERF_CNT_EN is defined.
//
// state   | meaning
// FETCH   | read instruction, PC += 4 when memory completes
// DECODE  | read registers, branch target into ALUOut
// MEMADR  | compute load/store address
// MEMRD   | load access, wait for memory
// MEMWB   | write loaded data to register file
// MEMWR   | store access, write once on completion
// EXECR   | R-type ALU operation
// EXECI   | addi ALU operation
// LUI     | pass upper immediate through ALU
// ALUWB   | write ALUOut to register file
// BRANCH  | compare, update PC if taken
// JAL     | return address into ALUOut, PC <= target
// TRAP    | unsupported opcode, held until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCUpdate,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             Branch,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = decode_next(opcode);
            S_MEMADR: state_next = (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_JAL: state_next = S_ALUWB;
            S_ALUWB, S_BRANCH: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    // Only the memory states look at mem_ready; everything else is pure Moore.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = mem_ready;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_LUI: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_LUI;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_A;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            ctrl = '0;
        end
    end

    assign mem_req   = ctrl.mem_req;
    assign PCUpdate  = ctrl.pc_update;
    assign IRWrite   = ctrl.ir_write;
    assign MemWrite  = ctrl.mem_write;
    assign RegWrite  = ctrl.reg_write;
    assign Branch    = ctrl.branch;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign ResultSrc = ctrl.result_src;
    assign illegal   = ctrl.illegal;
    assign state_o   = state;

`ifdef PERF_CNT_EN
    logic retire;

    assign retire = (state_next == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH});

    multicycle_control_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level reference model
// expands each instruction into its cycle sequence; a negedge monitor checks.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          mem_req, PCUpdate, IRWrite, MemWrite, RegWrite, Branch, AdrSrc;
    logic [1:0]    ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic          illegal;
    logic [3:0]    state_o;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCUpdate(PCUpdate), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .illegal(illegal),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0]   ctl;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ret;
        string         tag;
    } exp_t;

    typedef struct {
        state_t ph;
        logic   rdy;
    } cyc_t;

    exp_t q[$];
    cyc_t seq[$];
    int checks = 0;
    int failures = 0;
    logic [CW-1:0] cyc_m = '0;
    logic [CW-1:0] ret_m = '0;

    localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011,
                           T_I = 7'b0010011, T_BEQ = 7'b1100011, T_JAL = 7'b1101111,
                           T_LUI = 7'b0110111, T_BAD = 7'b1111111;
    logic [6:0] ops [8] = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL, T_LUI, T_BAD};

    // Expected outputs per state, straight from the state output tables.
    function automatic logic [19:0] expect_out(state_t ph, logic rdy, logic r);
        logic mr = 0, pcu = 0, irw = 0, mw = 0, rw = 0, br = 0, adr = 0, ill = 0;
        logic [1:0] a = 0, b = 0, op = 0, res = 0;
        case (ph)
            S_FETCH:  begin mr = 1; b = 2'b10; res = 2'b10; irw = rdy; pcu = rdy; end
            S_DECODE: begin a = 2'b01; b = 2'b01; end
            S_MEMADR: begin a = 2'b10; b = 2'b01; end
            S_MEMRD:  begin mr = 1; adr = 1; end
            S_MEMWB:  begin res = 2'b01; rw = 1; end
            S_MEMWR:  begin mr = 1; adr = 1; mw = rdy; end
            S_EXECR:  begin a = 2'b10; op = 2'b10; end
            S_EXECI:  begin a = 2'b10; b = 2'b01; end
            S_LUI:    begin b = 2'b01; op = 2'b11; end
            S_ALUWB:  begin rw = 1; end
            S_BRANCH: begin a = 2'b10; op = 2'b01; br = 1; end
            S_JAL:    begin a = 2'b01; b = 2'b10; pcu = 1; end
            S_TRAP:   begin ill = 1; end
            default: ;
        endcase
        if (r) begin
            {mr, pcu, irw, mw, rw, br, adr, ill} = '0;
            {a, b, op, res} = '0;
        end
        return {4'(ph), mr, pcu, irw, mw, rw, br, adr, a, b, op, res, ill};
    endfunction

    function automatic logic is_legal(logic [6:0] opc);
        return opc inside {T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL, T_LUI};
    endfunction

    // Expand one instruction into its cycle-by-cycle state sequence.
    task automatic build(input logic [6:0] opc, input int wf, input int wm);
        seq.delete();
        repeat (wf) seq.push_back('{S_FETCH, 1'b0});
        seq.push_back('{S_FETCH, 1'b1});
        seq.push_back('{S_DECODE, 1'($urandom)});
        case (opc)
            T_LW: begin
                seq.push_back('{S_MEMADR, 1'($urandom)});
                repeat (wm) seq.push_back('{S_MEMRD, 1'b0});
                seq.push_back('{S_MEMRD, 1'b1});
                seq.push_back('{S_MEMWB, 1'($urandom)});
            end
            T_SW: begin
                seq.push_back('{S_MEMADR, 1'($urandom)});
                repeat (wm) seq.push_back('{S_MEMWR, 1'b0});
                seq.push_back('{S_MEMWR, 1'b1});
            end
            T_R:   begin seq.push_back('{S_EXECR, 1'($urandom)}); seq.push_back('{S_ALUWB, 1'($urandom)}); end
            T_I:   begin seq.push_back('{S_EXECI, 1'($urandom)}); seq.push_back('{S_ALUWB, 1'($urandom)}); end
            T_LUI: begin seq.push_back('{S_LUI, 1'($urandom)});   seq.push_back('{S_ALUWB, 1'($urandom)}); end
            T_JAL: begin seq.push_back('{S_JAL, 1'($urandom)});   seq.push_back('{S_ALUWB, 1'($urandom)}); end
            T_BEQ: seq.push_back('{S_BRANCH, 1'($urandom)});
            default: repeat (10) seq.push_back('{S_TRAP, 1'($urandom)});
        endcase
    endtask

    task automatic run_cycle(input state_t ph, input logic rdy, input logic r,
                             input logic [6:0] opc, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        opcode = opc;
        mem_ready = rdy;
        e.ctl = expect_out(ph, rdy, r);
`ifdef PERF_CNT_EN
        e.cyc = cyc_m;
        e.ret = ret_m;
`else
        e.cyc = '0;
        e.ret = '0;
`endif
        e.tag = tag;
        q.push_back(e);
        if (r) begin
            cyc_m = '0;
            ret_m = '0;
        end else begin
            cyc_m = cyc_m + 1'b1;
        end
    endtask

    // cut >= 0 asserts reset during that cycle instead of completing the instruction.
    task automatic run_seq(input logic [6:0] opc, input int cut, input string tag);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == cut) begin
                run_cycle(seq[i].ph, seq[i].rdy, 1'b1, opc, tag);
                return;
            end
            run_cycle(seq[i].ph, seq[i].rdy, 1'b0, opc, tag);
        end
        if (is_legal(opc)) ret_m = ret_m + 1'b1;
        else run_cycle(S_TRAP, 1'($urandom), 1'b1, opc, tag);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [19:0] act;
            e = q.pop_front();
            act = {state_o, mem_req, PCUpdate, IRWrite, MemWrite, RegWrite, Branch,
                   AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal};
            checks++;
            if (act !== e.ctl) begin
                failures++;
                $display("FAIL %s ctl: got %h expected %h", e.tag, act, e.ctl);
            end
            checks++;
            if (cycle_cnt !== e.cyc) begin
                failures++;
                $display("FAIL %s cycle_cnt: got %0d expected %0d", e.tag, cycle_cnt, e.cyc);
            end
            checks++;
            if (instret_cnt !== e.ret) begin
                failures++;
                $display("FAIL %s instret_cnt: got %0d expected %0d", e.tag, instret_cnt, e.ret);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        opcode = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        build(T_LW, 0, 0);  run_seq(T_LW, -1, "lw");
        build(T_SW, 0, 3);  run_seq(T_SW, -1, "sw_wait");
        build(T_BEQ, 0, 0); run_seq(T_BEQ, -1, "beq");

        run_cycle(S_FETCH, 1'b1, 1'b1, 7'd0, "rst_pre_perf");
        build(T_R, 0, 0);   run_seq(T_R, -1, "perf_add");
        build(T_LUI, 0, 0); run_seq(T_LUI, -1, "perf_lui");
        build(T_JAL, 0, 0); run_seq(T_JAL, -1, "perf_jal");
        build(T_LW, 0, 2);  run_seq(T_LW, 4, "lw_rst_memrd");
        build(T_BAD, 0, 0); run_seq(T_BAD, -1, "trap");

        // Long reset-free stretch so the narrow counters wrap.
        for (int n = 0; n < 80; n++) begin
            logic [6:0] opc;
            opc = ops[$urandom_range(0, 6)];
            build(opc, $urandom_range(0, 2), $urandom_range(0, 3));
            run_seq(opc, -1, "rand_long");
        end

        for (int n = 0; n < 200; n++) begin
            logic [6:0] opc;
            int cut;
            opc = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
            build(opc, $urandom_range(0, 3), $urandom_range(0, 3));
            cut = -1;
            if (is_legal(opc) && $urandom_range(0, 9) == 0)
                cut = $urandom_range(1, seq.size() - 1);
            run_seq(opc, cut, "rand_mix");
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
